// File: rtl/alarm_controller.sv
// Purpose: 24h clock with alarm, buttons to set time/alarm, ringing buzzer with auto-timeout.
// Latency: all outputs registered; every input takes effect on the edge it is sampled.
// Backpressure: none; pulse inputs are consumed on the edge they arrive (buttons silence a ringing buzzer).
module alarm_controller #(
   parameter int RING_SECS = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       alarm_en,
   output logic [4:0] hours,
   output logic [5:0] minutes,
   output logic [5:0] seconds,
   output logic [4:0] alm_hours,
   output logic [5:0] alm_minutes,
   output logic [2:0] mode,
   output logic       buzzer,
   output logic       blink
);

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      SET_HR   = 3'd1,
      SET_MIN  = 3'd2,
      SET_AHR  = 3'd3,
      SET_AMIN = 3'd4
   } mode_t;

   mode_t      r_mode, w_mode_nxt;
   logic [4:0] r_hr,   w_hr_nxt;
   logic [5:0] r_min,  w_min_nxt;
   logic [5:0] r_sec,  w_sec_nxt;
   logic [4:0] r_ahr,  w_ahr_nxt;
   logic [5:0] r_amin, w_amin_nxt;
   logic       r_buzz, w_buzz_nxt;
   logic       r_blink, w_blink_nxt;
   logic [5:0] r_ring, w_ring_nxt;

   logic       w_adv, w_consume, w_sec_wrap, w_min_wrap, w_match;
   logic [5:0] w_sec_inc, w_min_inc, w_amin_inc, w_t_sec, w_t_min;
   logic [4:0] w_hr_inc, w_ahr_inc, w_t_hr;

   // Time runs everywhere except while the clock itself is being edited.
   assign w_adv     = tick_1hz && (r_mode == RUN || r_mode == SET_AHR || r_mode == SET_AMIN);
   // A button press while ringing only silences; it must not move the FSM or a field.
   assign w_consume = r_buzz && (btn_mode || btn_inc);

   assign w_sec_wrap = (r_sec == 6'd59);
   assign w_min_wrap = (r_min == 6'd59);
   assign w_sec_inc  = w_sec_wrap ? 6'd0 : r_sec + 6'd1;
   assign w_min_inc  = w_min_wrap ? 6'd0 : r_min + 6'd1;
   assign w_hr_inc   = (r_hr == 5'd23) ? 5'd0 : r_hr + 5'd1;
   assign w_ahr_inc  = (r_ahr == 5'd23) ? 5'd0 : r_ahr + 5'd1;
   assign w_amin_inc = (r_amin == 6'd59) ? 6'd0 : r_amin + 6'd1;

   // Time value after one carrying tick; the alarm compares against this, not the current time.
   assign w_t_sec = w_sec_inc;
   assign w_t_min = w_sec_wrap ? w_min_inc : r_min;
   assign w_t_hr  = (w_sec_wrap && w_min_wrap) ? w_hr_inc : r_hr;
   assign w_match = (w_t_hr == r_ahr) && (w_t_min == r_amin) && (w_t_sec == 6'd0);

   // Next-state and next-field computation for the whole controller.
   always_comb begin
      w_mode_nxt  = r_mode;
      w_hr_nxt    = r_hr;
      w_min_nxt   = r_min;
      w_sec_nxt   = r_sec;
      w_ahr_nxt   = r_ahr;
      w_amin_nxt  = r_amin;
      w_buzz_nxt  = r_buzz;
      w_ring_nxt  = r_ring;
      w_blink_nxt = r_blink;

      if (w_adv) begin
         w_hr_nxt  = w_t_hr;
         w_min_nxt = w_t_min;
         w_sec_nxt = w_t_sec;
      end

      if (!w_consume) begin
         if (btn_mode) begin
            case (r_mode)
               RUN:      w_mode_nxt = SET_HR;
               SET_HR:   w_mode_nxt = SET_MIN;
               SET_MIN:  w_mode_nxt = SET_AHR;
               SET_AHR:  w_mode_nxt = SET_AMIN;
               default:  w_mode_nxt = RUN;
            endcase
            // Leaving clock-minute edit restarts the minute cleanly.
            if (r_mode == SET_MIN) w_sec_nxt = 6'd0;
         end else if (btn_inc) begin
            case (r_mode)
               SET_HR:   w_hr_nxt   = w_hr_inc;
               SET_MIN:  w_min_nxt  = w_min_inc;
               SET_AHR:  w_ahr_nxt  = w_ahr_inc;
               SET_AMIN: w_amin_nxt = w_amin_inc;
               default:  ;
            endcase
         end
      end

      if (r_buzz) begin
         if (w_consume || !alarm_en) begin
            w_buzz_nxt = 1'b0;
            w_ring_nxt = 6'd0;
         end else if (tick_1hz) begin
            w_ring_nxt = (r_ring == 6'd0) ? 6'd0 : r_ring - 6'd1;
            if (r_ring <= 6'd1) w_buzz_nxt = 1'b0;
         end
      end else if (w_adv && alarm_en && w_match) begin
         w_buzz_nxt = 1'b1;
         w_ring_nxt = 6'(RING_SECS);
      end

      if (w_mode_nxt == RUN)
         w_blink_nxt = 1'b0;
      else if (tick_1hz && r_mode != RUN)
         w_blink_nxt = ~r_blink;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) r_mode <= RUN;
      else      r_mode <= w_mode_nxt;
   end

   // Time, alarm, ring and display registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_hr    <= 5'd0;
         r_min   <= 6'd0;
         r_sec   <= 6'd0;
         r_ahr   <= 5'd0;
         r_amin  <= 6'd0;
         r_buzz  <= 1'b0;
         r_ring  <= 6'd0;
         r_blink <= 1'b0;
      end else begin
         r_hr    <= w_hr_nxt;
         r_min   <= w_min_nxt;
         r_sec   <= w_sec_nxt;
         r_ahr   <= w_ahr_nxt;
         r_amin  <= w_amin_nxt;
         r_buzz  <= w_buzz_nxt;
         r_ring  <= w_ring_nxt;
         r_blink <= w_blink_nxt;
      end
   end

   assign hours       = r_hr;
   assign minutes     = r_min;
   assign seconds     = r_sec;
   assign alm_hours   = r_ahr;
   assign alm_minutes = r_amin;
   assign mode        = r_mode;
   assign buzzer      = r_buzz;
   assign blink       = r_blink;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed sequences, expected snapshots queued by the stimulus,
// compared by an independent monitor on the falling edge.
module tb_alarm_controller;

   typedef struct packed {
      logic [4:0] hr;
      logic [5:0] mi;
      logic [5:0] se;
      logic [4:0] ahr;
      logic [5:0] ami;
      logic [2:0] md;
      logic       bz;
      logic       bl;
   } snap_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick_1hz = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0, alarm_en = 1'b0;
   logic [4:0] hours, alm_hours;
   logic [5:0] minutes, seconds, alm_minutes;
   logic [2:0] mode;
   logic       buzzer, blink;

   alarm_controller #(.RING_SECS(30)) dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .alarm_en(alarm_en), .hours(hours), .minutes(minutes), .seconds(seconds),
      .alm_hours(alm_hours), .alm_minutes(alm_minutes), .mode(mode), .buzzer(buzzer), .blink(blink)
   );

   always #5 clk = ~clk;

   snap_t exp_s;
   snap_t q_exp[$];
   string q_nm[$];
   int    n_chk  = 0;
   int    n_pass = 0;
   logic  done   = 1'b0;

   task automatic step(input logic t, input logic m, input logic i);
      tick_1hz = t; btn_mode = m; btn_inc = i;
      @(posedge clk); #1;
      tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) step(1'b1, 1'b0, 1'b0);
   endtask

   task automatic chk(input string nm);
      q_exp.push_back(exp_s);
      q_nm.push_back(nm);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick_1hz = 1'($urandom); btn_mode = 1'($urandom);
      btn_inc = 1'($urandom); alarm_en = 1'($urandom);
      @(posedge clk); #1;
      rst = 1'b1; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
   endtask

   // Monitor: compares every queued expectation against the settled DUT outputs.
   initial begin
      snap_t a, e;
      string nm;
      forever begin
         @(negedge clk);
         while (q_exp.size() > 0) begin
            e  = q_exp.pop_front();
            nm = q_nm.pop_front();
            a  = {hours, minutes, seconds, alm_hours, alm_minutes, mode, buzzer, blink};
            n_chk++;
            if (a === e) n_pass++;
            else $display("FAIL %s: got %0d:%0d:%0d alm %0d:%0d mode %0d bz %0b bl %0b, want %0d:%0d:%0d alm %0d:%0d mode %0d bz %0b bl %0b",
                          nm, a.hr, a.mi, a.se, a.ahr, a.ami, a.md, a.bz, a.bl,
                          e.hr, e.mi, e.se, e.ahr, e.ami, e.md, e.bz, e.bl);
         end
      end
   end

   initial begin
      #200000;
      if (!done) begin
         $display("FAIL watchdog: sequence did not complete, checked %0d", n_chk);
         $fatal(1, "timeout");
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      // Reset with random inputs
      do_reset();
      alarm_en = 1'b0;
      exp_s = '0;
      chk("reset");

      // Hours wrap in SET_HR, time frozen, blink toggles
      step(0, 1, 0); exp_s.md = 3'd1; chk("to_sethr");
      repeat (23) step(0, 0, 1); exp_s.hr = 5'd23; chk("hr23");
      step(0, 0, 1); exp_s.hr = 5'd0; chk("hr_wrap");
      ticks(1); exp_s.bl = 1'b1; chk("sethr_tick1");
      ticks(1); exp_s.bl = 1'b0; chk("sethr_tick2");

      // Rollover 23:59:59 -> 00:00:00
      repeat (23) step(0, 0, 1); exp_s.hr = 5'd23;
      step(0, 1, 0); exp_s.md = 3'd2;
      repeat (59) step(0, 0, 1); exp_s.mi = 6'd59; chk("min59");
      step(0, 1, 0); step(0, 1, 0); step(0, 1, 0); exp_s.md = 3'd0; chk("back_run");
      ticks(59); exp_s.se = 6'd59; chk("t235959");
      ticks(1); exp_s.hr = 5'd0; exp_s.mi = 6'd0; exp_s.se = 6'd0; chk("rollover");

      // Mode beats inc, seconds frozen in SET_MIN, cleared on exit, tick+inc in SET_AHR
      ticks(5); exp_s.se = 6'd5;
      step(0, 1, 1); exp_s.md = 3'd1; chk("mode_wins");
      step(0, 1, 0); exp_s.md = 3'd2;
      ticks(1); exp_s.bl = 1'b1; chk("setmin_tick");
      step(0, 1, 0); exp_s.md = 3'd3; exp_s.se = 6'd0; chk("sec_clear");
      step(1, 0, 1); exp_s.ahr = 5'd1; exp_s.se = 6'd1; exp_s.bl = 1'b0; chk("ahr_inc_tick");
      repeat (23) step(0, 0, 1); exp_s.ahr = 5'd0; chk("ahr_wrap");
      step(0, 1, 0); exp_s.md = 3'd4;
      step(0, 0, 1); exp_s.ami = 6'd1;
      step(0, 1, 0); exp_s.md = 3'd0; chk("alarm_set");

      // Alarm 00:01 triggers and rings 30 ticks
      ticks(58); exp_s.se = 6'd59; chk("pre_trigger");
      alarm_en = 1'b1;
      ticks(1); exp_s.mi = 6'd1; exp_s.se = 6'd0; exp_s.bz = 1'b1; chk("trigger");
      ticks(29); exp_s.se = 6'd29; chk("ringing");
      ticks(1); exp_s.se = 6'd30; exp_s.bz = 1'b0; chk("ring_end");

      // Alarm 00:02, silenced by btn_inc
      step(0, 1, 0); step(0, 1, 0); step(0, 1, 0); exp_s.md = 3'd3; exp_s.se = 6'd0;
      step(0, 1, 0); exp_s.md = 3'd4;
      step(0, 0, 1); exp_s.ami = 6'd2;
      step(0, 1, 0); exp_s.md = 3'd0; chk("alarm_set2");
      ticks(60); exp_s.mi = 6'd2; exp_s.bz = 1'b1; chk("trigger2");
      step(0, 0, 1); exp_s.bz = 1'b0; chk("silence");

      // Alarm 00:03, reset mid-ring
      step(0, 1, 0); step(0, 1, 0); step(0, 1, 0); step(0, 1, 0); exp_s.md = 3'd4;
      step(0, 0, 1); exp_s.ami = 6'd3;
      step(0, 1, 0); exp_s.md = 3'd0;
      ticks(60); exp_s.mi = 6'd3; exp_s.bz = 1'b1; chk("trigger3");
      do_reset();
      alarm_en = 1'b1;
      exp_s = '0; chk("reset_midring");
      ticks(5); exp_s.se = 6'd5; chk("no_retrigger");

      repeat (3) @(posedge clk);
      if (q_exp.size() != 0) begin
         n_chk++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", q_exp.size());
      end
      done = 1'b1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 Parameter: RING_SECS, default 30, alarm ring duration in seconds (1..63).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 tick_1hz  input  1  one-clk-wide pulse once per second from the clock divider.
REQ-005 btn_mode  input  1  one-clk-wide pulse (pre-debounced); advances set mode.
REQ-006 btn_inc  input  1  one-clk-wide pulse (pre-debounced); increments the field being set.
REQ-007 alarm_en  input  1  level; 1 = alarm armed.
REQ-008 hours  output  5  current hours, 0..23.
REQ-009 minutes  output  6  current minutes, 0..59.
REQ-010 seconds  output  6  current seconds, 0..59.
REQ-011 alm_hours  output  5  alarm hours, 0..23.
REQ-012 alm_minutes  output  6  alarm minutes, 0..59.
REQ-013 mode  output  3  FSM state: RUN=0, SET_HR=1, SET_MIN=2, SET_AHR=3, SET_AMIN=4.
REQ-014 buzzer  output  1  1 while alarm rings.
REQ-015 blink  output  1  display blink phase for the field being set.

Function
REQ-016 FSM SHALL advance RUN->SET_HR->SET_MIN->SET_AHR->SET_AMIN->RUN, one step per btn_mode pulse, on the same edge.
REQ-017 In RUN, SET_AHR, SET_AMIN: each tick_1hz SHALL increment seconds; 59->0 carries into minutes; minutes 59->0 carries into hours; hours 23->0.
REQ-018 In SET_HR, SET_MIN: tick_1hz SHALL NOT change the time counters.
REQ-019 btn_inc SHALL increment, without carry, hours (SET_HR, 23->0), minutes (SET_MIN, 59->0), alm_hours (SET_AHR, 23->0), alm_minutes (SET_AMIN, 59->0); ignored in RUN.
REQ-020 Transition SET_MIN->SET_AHR SHALL clear seconds to 0 on the same edge.
REQ-021 btn_mode and btn_inc on the same cycle: mode advance wins, btn_inc ignored.
REQ-022 tick_1hz and btn_inc on the same cycle in SET_AHR/SET_AMIN: both take effect.
REQ-023 Alarm trigger: on a tick edge where the next time value equals alm_hours:alm_minutes:00, alarm_en=1 and buzzer=0, buzzer SHALL go 1 on that same edge and an internal ring counter SHALL load RING_SECS.
REQ-024 While buzzer=1, each tick_1hz SHALL decrement the ring counter; buzzer SHALL clear on the tick edge where the counter goes 1->0 (RING_SECS ticks after trigger).
REQ-025 While buzzer=1, any btn_mode or btn_inc SHALL clear buzzer and be consumed (no mode or field change).
REQ-026 alarm_en=0 SHALL clear buzzer on the next edge and block new triggers.
REQ-027 Triggers are evaluated in every mode where time advances; no trigger in SET_HR/SET_MIN.
REQ-028 blink SHALL be 0 in RUN, toggle on every tick_1hz in set modes, and clear on entry to RUN.
REQ-029 Counter values SHALL never leave their stated ranges; all outputs registered.

Reset
REQ-030 With rst=0 at a rising edge: hours, minutes, seconds, alm_hours, alm_minutes=0; mode=RUN; buzzer=0; blink=0; ring counter=0; reset overrides all other inputs, including mid-ring and mid-set.

Verification
REQ-031 Reset: assert rst=0 one edge with random inputs -> all outputs 0, mode=0.
REQ-032 Rollover: SET_HR 23 incs, SET_MIN 59 incs, mode x3 to RUN, 59 ticks -> 23:59:59; next tick -> 00:00:00.
REQ-033 Wrap in set: from reset, mode to SET_HR, 24 btn_inc -> hours=0; ticks during SET_HR leave seconds=0; blink toggles per tick.
REQ-034 Alarm: alarm 00:01, alarm_en=1, time 00:00:00 in RUN, 60 ticks -> buzzer=1 on edge minutes=1, seconds=0; 30 more ticks -> buzzer=0 at 00:01:30.
REQ-035 Silence: while ringing, btn_inc -> buzzer=0, mode and alarm fields unchanged; btn_mode+btn_inc same cycle when idle -> mode advances only.
REQ-036 Reset mid-ring: buzzer=1, rst=0 one edge -> buzzer=0, time 00:00:00, no retrigger until next match.
